qam_sym_ctrl: RTL and testbench

- Symbol-timing controller for the QAM modulator.
- Accepts 16-QAM symbols over a valid/ready handshake and maps each to signed I/Q levels.
- Holds each symbol's levels for a programmable number of clock cycles, and drives the frequency step word and phase-sync pulse for the carrier generators.
- Sits between the bit/symbol source and the I/Q multipliers that are fed by the sine/cosine generators.

---
 rtl/qam_pkg.sv | 30 +++
 rtl/qam_sym_ctrl_if.sv | 12 +
 rtl/qam_level_map.sv | 14 +
 rtl/qam_sym_ctrl.sv | 165 ++++++++++++++++
 tb/tb_qam_sym_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol-timing controller: controller states,
// 16-QAM Gray-coded amplitude levels and the bit-pair to level mapping.
package qam_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [3:0] sym_t;

    localparam logic signed [2:0] LVL_M3 = -3'sd3;
    localparam logic signed [2:0] LVL_M1 = -3'sd1;
    localparam logic signed [2:0] LVL_P1 = 3'sd1;
    localparam logic signed [2:0] LVL_P3 = 3'sd3;

    // Gray map: adjacent levels differ in one bit so a one-level slip costs one bit error.
    function automatic logic signed [2:0] qam16_map(input logic [1:0] bits);
        case (bits)
            2'b00:   qam16_map = LVL_M3;
            2'b01:   qam16_map = LVL_M1;
            2'b11:   qam16_map = LVL_P1;
            default: qam16_map = LVL_P3;
        endcase
    endfunction

endpackage

// File: rtl/qam_sym_ctrl_if.sv
// Symbol handshake between the bit/symbol source and the timing controller.
interface qam_sym_ctrl_if;
    import qam_pkg::*;

    sym_t sym_data;
    logic sym_valid;
    logic sym_ready;

    modport master (output sym_data, output sym_valid, input sym_ready);
    modport slave  (input sym_data, input sym_valid, output sym_ready);

endinterface

// File: rtl/qam_level_map.sv
// Combinational map from one Gray-coded bit pair to a signed amplitude level.
module qam_level_map
    import qam_pkg::*;
#(
    parameter int LVL_W = 3
) (
    input  logic [1:0]              bits_i,
    output logic signed [LVL_W-1:0] level_o
);

    // Size cast of a signed value sign-extends for wider level buses.
    assign level_o = LVL_W'(qam16_map(bits_i));

endmodule

// File: rtl/qam_sym_ctrl.sv
// Symbol-timing controller: accepts 16-QAM symbols, holds their I/Q levels for
// a programmable number of cycles and drives the carrier step word and sync.
module qam_sym_ctrl
    import qam_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int CNT_W        = 16,
    parameter int LVL_W        = 3,
    parameter int INIT_STEP    = 1,
    parameter int INIT_SYM_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    cfg_load,
    input  logic [ADDR_WIDTH-3:0]   cfg_step,
    input  logic [CNT_W-1:0]        cfg_sym_len,
    qam_sym_ctrl_if.slave           sym_if,
    output logic [ADDR_WIDTH-3:0]   step_out,
    output logic                    carrier_sync,
    output logic signed [LVL_W-1:0] i_level,
    output logic signed [LVL_W-1:0] q_level,
    output logic                    mod_en,
    output logic                    sym_strobe,
    output logic                    underrun,
    output logic                    busy
);

    localparam int STEP_W = ADDR_WIDTH - 2;
    localparam logic [STEP_W-1:0] STEP_RST = STEP_W'(INIT_STEP);
    localparam logic [CNT_W-1:0]  LEN_RST  = CNT_W'(INIT_SYM_LEN);

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [CNT_W-1:0]        sh_len_q, sh_len_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [STEP_W-1:0]       sh_step_q, sh_step_d;
    logic                    stop_pend_q, stop_pend_d;
    logic signed [LVL_W-1:0] i_q, i_d, q_q, q_d;
    logic signed [LVL_W-1:0] i_map, q_map;
    logic                    mod_en_q, mod_en_d;
    logic                    strobe_q, strobe_d;
    logic                    under_q, under_d;
    logic                    sync_q, sync_d;
    logic                    boundary;
    logic                    run;

    qam_level_map #(.LVL_W(LVL_W)) u_map_i (.bits_i(sym_if.sym_data[3:2]), .level_o(i_map));
    qam_level_map #(.LVL_W(LVL_W)) u_map_q (.bits_i(sym_if.sym_data[1:0]), .level_o(q_map));

    assign run      = (state_q == ST_RUN);
    assign boundary = (cnt_q == '0);

    // Ready is decoded from registers only, so the source sees no path from its own valid.
    assign sym_if.sym_ready = run && boundary && !stop_pend_q;

    assign step_out     = step_q;
    assign carrier_sync = sync_q;
    assign i_level      = i_q;
    assign q_level      = q_q;
    assign mod_en       = mod_en_q;
    assign sym_strobe   = strobe_q;
    assign underrun     = under_q;
    assign busy         = run;

    // Next-state: shadow config capture, IDLE/RUN sequencing and symbol-period timing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        step_d      = step_q;
        sh_len_d    = sh_len_q;
        sh_step_d   = sh_step_q;
        stop_pend_d = stop_pend_q;
        i_d         = i_q;
        q_d         = q_q;
        mod_en_d    = mod_en_q;
        strobe_d    = 1'b0;
        under_d     = 1'b0;
        sync_d      = 1'b0;

        if (cfg_load) begin
            sh_step_d = cfg_step;
            sh_len_d  = (cfg_sym_len == '0) ? CNT_W'(1) : cfg_sym_len;
        end

        if (!run) begin
            // Active config tracks the shadow while idle.
            step_d = sh_step_q;
            len_d  = sh_len_q;
            if (start && !stop) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                sync_d  = 1'b1;
            end
        end else begin
            if (stop) begin
                stop_pend_d = 1'b1;
            end
            if (boundary) begin
                // The pre-load shadow is used, so a load on this cycle lands one boundary later.
                step_d = sh_step_q;
                len_d  = sh_len_q;
                if (stop_pend_q) begin
                    state_d     = ST_IDLE;
                    stop_pend_d = 1'b0;
                    i_d         = '0;
                    q_d         = '0;
                    mod_en_d    = 1'b0;
                end else begin
                    cnt_d    = sh_len_q - CNT_W'(1);
                    mod_en_d = 1'b1;
                    strobe_d = 1'b1;
                    if (sym_if.sym_valid) begin
                        i_d = i_map;
                        q_d = q_map;
                    end else begin
                        // Zero symbol keeps the symbol grid intact when the source starves.
                        i_d     = '0;
                        q_d     = '0;
                        under_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State and output registers; reset aborts any symbol in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= LEN_RST;
            sh_len_q    <= LEN_RST;
            step_q      <= STEP_RST;
            sh_step_q   <= STEP_RST;
            stop_pend_q <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
            mod_en_q    <= 1'b0;
            strobe_q    <= 1'b0;
            under_q     <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sh_len_q    <= sh_len_d;
            step_q      <= step_d;
            sh_step_q   <= sh_step_d;
            stop_pend_q <= stop_pend_d;
            i_q         <= i_d;
            q_q         <= q_d;
            mod_en_q    <= mod_en_d;
            strobe_q    <= strobe_d;
            under_q     <= under_d;
            sync_q      <= sync_d;
        end
    end

endmodule

// File: tb/tb_qam_sym_ctrl.sv
// Scoreboard bench for qam_sym_ctrl: every accepted symbol or starved boundary
// pushes its expected levels and duration; each sym_strobe pops and compares.
module tb_qam_sym_ctrl;

    typedef struct {
        int i;
        int q;
        int len;
        int und;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              cfg_load;
    logic [9:0]        cfg_step;
    logic [15:0]       cfg_sym_len;
    logic [9:0]        step_out;
    logic              carrier_sync;
    logic signed [2:0] i_level;
    logic signed [2:0] q_level;
    logic              mod_en;
    logic              sym_strobe;
    logic              underrun;
    logic              busy;

    qam_sym_ctrl_if sym_if ();

    qam_sym_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .cfg_load     (cfg_load),
        .cfg_step     (cfg_step),
        .cfg_sym_len  (cfg_sym_len),
        .sym_if       (sym_if),
        .step_out     (step_out),
        .carrier_sync (carrier_sync),
        .i_level      (i_level),
        .q_level      (q_level),
        .mod_en       (mod_en),
        .sym_strobe   (sym_strobe),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   src_q[$];
    exp_t cur;
    int   in_sym = 0;
    int   run_cnt = 0;
    int   m_len = 16;
    int   sync_cnt = 0;
    int   und_cnt = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int gray_lvl(input logic [1:0] b);
        case (b)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    // Monitor: compare strobed symbols and their hold time, then record new boundaries.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            in_sym = 0;
            m_len  = 16;
        end else begin
            if (carrier_sync) sync_cnt++;
            if (underrun) und_cnt++;
            if (sym_strobe) begin
                if (in_sym != 0) check_val("sym_len", run_cnt, cur.len);
                if (exp_q.size() == 0) begin
                    check_val("strobe_unexpected", exp_q.size(), 1);
                    in_sym = 0;
                end else begin
                    cur = exp_q.pop_front();
                    check_val("i_level", i_level, cur.i);
                    check_val("q_level", q_level, cur.q);
                    check_val("underrun", underrun, cur.und);
                    check_val("mod_en_on", mod_en, 1);
                    in_sym  = 1;
                    run_cnt = 1;
                end
            end else if (in_sym != 0) begin
                if (!mod_en) begin
                    check_val("sym_len", run_cnt, cur.len);
                    in_sym = 0;
                end else begin
                    run_cnt++;
                    check_val("hold_i", i_level, cur.i);
                    check_val("hold_q", q_level, cur.q);
                end
            end
            if (sym_if.sym_ready) begin
                e.len = m_len;
                if (sym_if.sym_valid) begin
                    e.i   = gray_lvl(sym_if.sym_data[3:2]);
                    e.q   = gray_lvl(sym_if.sym_data[1:0]);
                    e.und = 0;
                end else begin
                    e.i   = 0;
                    e.q   = 0;
                    e.und = 1;
                end
                exp_q.push_back(e);
            end
            if (cfg_load) m_len = (cfg_sym_len == 16'd0) ? 1 : int'(cfg_sym_len);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src();
        if (src_q.size() == 0 || src_q[0] < 0) begin
            sym_if.sym_valid = 1'b0;
        end else begin
            sym_if.sym_valid = 1'b1;
            sym_if.sym_data  = 4'(src_q[0]);
        end
    endtask

    task automatic do_cfg(input int step, input int len);
        cfg_step    = 10'(step);
        cfg_sym_len = 16'(len);
        cfg_load    = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick();
        tick();
    endtask

    // Start, feed src_q, optionally stop at cycle stop_k or reload length at rc_k; wait for IDLE.
    task automatic run_seq(input int stop_k, input int rc_k, input int rc_len,
                           input int exp_step, input int exp_und);
        int k;
        int sync0;
        int und0;
        bit hs;
        bit auto_stop;
        sync0     = sync_cnt;
        und0      = und_cnt;
        auto_stop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_busy", busy, 1);
        check_val("start_ready", sym_if.sym_ready, 1);
        k = 0;
        while (busy && k < 400) begin
            drive_src();
            if (k == rc_k) begin
                cfg_load    = 1'b1;
                cfg_sym_len = 16'(rc_len);
            end else begin
                cfg_load = 1'b0;
            end
            stop      = (k == stop_k) || auto_stop;
            auto_stop = 1'b0;
            if (k == 1) begin
                check_val("latency_mod_en", mod_en, 1);
                check_val("step_out", step_out, exp_step);
            end
            if (stop_k >= 0 && k == stop_k + 2) check_val("stop_no_ready", sym_if.sym_ready, 0);
            @(negedge clk);
            hs = sym_if.sym_ready;
            tick();
            if (hs && src_q.size() > 0) begin
                void'(src_q.pop_front());
                if (src_q.size() == 0 && stop_k < 0) auto_stop = 1'b1;
            end
            k++;
        end
        cfg_load         = 1'b0;
        stop             = 1'b0;
        sym_if.sym_valid = 1'b0;
        src_q.delete();
        check_val("run_cycle_budget", (k < 400) ? 1 : 0, 1);
        check_val("idle_mod_en", mod_en, 0);
        check_val("carrier_sync_pulses", sync_cnt - sync0, 1);
        check_val("underrun_pulses", und_cnt - und0, exp_und);
        tick();
    endtask

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        stop             = 1'b0;
        cfg_load         = 1'b0;
        cfg_step         = '0;
        cfg_sym_len      = '0;
        sym_if.sym_valid = 1'b0;
        sym_if.sym_data  = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_val("rst_mod_en", mod_en, 0);
        check_val("rst_i", i_level, 0);
        check_val("rst_q", q_level, 0);
        check_val("rst_step", step_out, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", sym_if.sym_ready, 0);
        check_val("rst_strobe", sym_strobe, 0);
        check_val("rst_underrun", underrun, 0);
        check_val("rst_sync", carrier_sync, 0);

        // Basic run: two symbols back to back at 4 samples each.
        do_cfg(8, 4);
        src_q = '{4'b0010, 4'b1101};
        run_seq(-1, -1, 0, 8, 0);

        // One starved boundary between two symbols.
        do_cfg(8, 3);
        src_q = '{4'h5, -1, 4'hA};
        run_seq(-1, -1, 0, 8, 1);

        // Length reload on a boundary cycle lands one symbol later.
        do_cfg(8, 4);
        src_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        run_seq(-1, 4, 2, 8, 0);

        // Stop mid-symbol with a symbol still waiting.
        do_cfg(8, 5);
        src_q = '{4'h7, 4'hE};
        run_seq(3, -1, 0, 8, 0);

        // Zero length behaves as one sample per symbol.
        do_cfg(12, 0);
        src_q = '{4'h0, 4'hF, 4'h3};
        run_seq(-1, -1, 0, 12, 1);

        // start and stop together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check_val("start_stop_busy", busy, 0);
        check_val("start_stop_sync", carrier_sync, 0);

        // Reset in the middle of a running symbol.
        do_cfg(5, 6);
        src_q = '{4'h9};
        drive_src();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check_val("midrun_mod_en_before", mod_en, 1);
        rst = 1'b1;
        #1;
        check_val("midrun_rst_mod_en", mod_en, 0);
        check_val("midrun_rst_busy", busy, 0);
        check_val("midrun_rst_i", i_level, 0);
        check_val("midrun_rst_q", q_level, 0);
        check_val("midrun_rst_step", step_out, 1);
        check_val("midrun_rst_ready", sym_if.sym_ready, 0);
        src_q.delete();
        sym_if.sym_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_val("post_rst_step", step_out, 1);
        check_val("post_rst_busy", busy, 0);

        check_val("scoreboard_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
